// File: rtl/console_pkg.sv
// Shared definitions for the VGA text-console writer: FSM states, control
// codes and the vmem address layout (row in the upper bits, column in the
// lower ROW_SHIFT bits).
package console_pkg;

    localparam int VMEM_AW   = 12;
    localparam int ROW_SHIFT = 7;
    localparam int ROW_W     = VMEM_AW - ROW_SHIFT;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [2:0] {
        CLR_ALL,
        IDLE,
        WRITE,
        CLR_ROW,
        ERASE,
        DRAW
    } state_t;

    // vmem address of a cell: col | (row << ROW_SHIFT)
    function automatic logic [VMEM_AW-1:0] cell_addr(
        input logic [ROW_W-1:0]     row,
        input logic [ROW_SHIFT-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/vga_console_writer_if.sv
// Byte handshake from the CPU plus the vmem write port and cursor position
// of the console writer. The master side is the byte source / observer.
interface vga_console_writer_if;
    import console_pkg::*;

    logic [7:0]                 char_in;
    logic                       char_valid;
    logic                       char_ready;
    logic [VMEM_AW-1:0]         vmem_addr;
    logic [7:0]                 vmem_data;
    logic                       vmem_we;
    logic [ROW_SHIFT-1:0]       cursor_col;
    logic [ROW_W-1:0]           cursor_row;

    modport master (
        output char_in, char_valid,
        input  char_ready, vmem_addr, vmem_data, vmem_we, cursor_col, cursor_row
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, vmem_addr, vmem_data, vmem_we, cursor_col, cursor_row
    );
endinterface

// File: rtl/console_cursor.sv
// Cursor position registers. inc wraps at the last column and reports the
// resulting row advance on o_advance; dec saturates at column 0 and never
// moves to the previous row.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    input  logic                 i_dec,
    input  logic                 i_home_col,
    input  logic                 i_newline,
    input  logic                 i_home,
    output logic [ROW_SHIFT-1:0] o_col,
    output logic [ROW_W-1:0]     o_row,
    output logic                 o_advance,
    output logic [VMEM_AW-1:0]   o_addr
);

    localparam logic [ROW_SHIFT-1:0] LAST_COL = ROW_SHIFT'(COLS - 1);
    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_SHIFT-1:0] r_col;
    logic [ROW_W-1:0]     r_row;
    logic                 w_row_adv;

    assign o_advance = i_inc && (r_col == LAST_COL);
    assign w_row_adv = o_advance || i_newline;
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_addr    = cell_addr(r_row, r_col);

    // Column/row update; row wraps from the last row back to the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_home) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            if (i_inc) begin
                r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
            end else if (i_dec) begin
                r_col <= (r_col == '0) ? '0 : r_col - 1'b1;
            end else if (i_home_col || i_newline) begin
                r_col <= '0;
            end
            if (w_row_adv) begin
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_console_writer.sv
// Character-stream writer for the 80x30 text vmem. Accepts one byte per
// handshake, interprets CR/LF/BS/FF, writes glyphs at the cursor and blanks
// rows as the cursor enters them. All vmem outputs are registered, so each
// write strobe appears one cycle after the state that produced it.
// Optional cursor glyph drawing: define CONSOLE_CURSOR_EN.
module vga_console_writer
    import console_pkg::*;
#(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [7:0] BLANK        = 8'h20,
    parameter logic [7:0] CURSOR_GLYPH = 8'h5F
) (
    input  logic                 clk50_in,
    input  logic                 rst,
    vga_console_writer_if.slave  bus
);

`ifdef CONSOLE_CURSOR_EN
    localparam state_t ST_AFTER_CLR = DRAW;
`else
    localparam state_t ST_AFTER_CLR = IDLE;
`endif

    state_t                r_state, w_state_next;
    logic [VMEM_AW-1:0]    r_cnt, w_cnt_next;

    // Work latched at accept time and replayed by WRITE.
    logic                  r_pend_we, w_pend_we_n;
    logic [VMEM_AW-1:0]    r_pend_addr, w_pend_addr_n;
    logic [7:0]            r_pend_data, w_pend_data_n;
    logic                  r_pend_adv, w_pend_adv_n;
`ifdef CONSOLE_CURSOR_EN
    logic                  r_pend_draw, w_pend_draw_n;
    logic [VMEM_AW-1:0]    r_erase_addr, w_erase_addr_n;
    state_t                r_pend_after, w_pend_after_n;
`else
    logic                  w_unused_cfg;
    assign w_unused_cfg = ^CURSOR_GLYPH;
`endif

    logic                  r_vmem_we;
    logic [VMEM_AW-1:0]    r_vmem_addr;
    logic [7:0]            r_vmem_data;
    logic                  w_we;
    logic [VMEM_AW-1:0]    w_addr;
    logic [7:0]            w_data;

    logic                  w_inc, w_dec, w_home_col, w_newline, w_home;
    logic [ROW_SHIFT-1:0]  w_col;
    logic [ROW_W-1:0]      w_row;
    logic                  w_advance;
    logic [VMEM_AW-1:0]    w_cur_addr;

    console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk        (clk50_in),
        .rst        (rst),
        .i_inc      (w_inc),
        .i_dec      (w_dec),
        .i_home_col (w_home_col),
        .i_newline  (w_newline),
        .i_home     (w_home),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_advance  (w_advance),
        .o_addr     (w_cur_addr)
    );

    assign bus.char_ready = (r_state == IDLE);
    assign bus.vmem_we    = r_vmem_we;
    assign bus.vmem_addr  = r_vmem_addr;
    assign bus.vmem_data  = r_vmem_data;
    assign bus.cursor_col = w_col;
    assign bus.cursor_row = w_row;

    // Next-state, byte decode, cursor commands and the write to be registered.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = '0;
        w_we          = 1'b0;
        w_addr        = '0;
        w_data        = '0;
        w_inc         = 1'b0;
        w_dec         = 1'b0;
        w_home_col    = 1'b0;
        w_newline     = 1'b0;
        w_home        = 1'b0;
        w_pend_we_n   = r_pend_we;
        w_pend_addr_n = r_pend_addr;
        w_pend_data_n = r_pend_data;
        w_pend_adv_n  = r_pend_adv;
`ifdef CONSOLE_CURSOR_EN
        w_pend_draw_n  = r_pend_draw;
        w_erase_addr_n = r_erase_addr;
        w_pend_after_n = r_pend_after;
`endif
        unique case (r_state)
            CLR_ALL: begin
                w_we       = 1'b1;
                w_addr     = r_cnt;
                w_data     = BLANK;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == '1) w_state_next = ST_AFTER_CLR;
            end
            IDLE: begin
                if (bus.char_valid) begin
                    w_state_next  = WRITE;
                    w_pend_we_n   = 1'b0;
                    w_pend_adv_n  = 1'b0;
                    w_pend_addr_n = w_cur_addr;
                    w_pend_data_n = bus.char_in;
`ifdef CONSOLE_CURSOR_EN
                    w_pend_draw_n  = 1'b0;
                    w_erase_addr_n = w_cur_addr;
`endif
                    if (bus.char_in >= 8'h20) begin
                        w_inc        = 1'b1;
                        w_pend_we_n  = 1'b1;
                        w_pend_adv_n = w_advance;
`ifdef CONSOLE_CURSOR_EN
                        w_pend_draw_n = 1'b1;
`endif
                    end else begin
                        case (bus.char_in)
                            CC_CR: begin
                                w_home_col = 1'b1;
`ifdef CONSOLE_CURSOR_EN
                                w_state_next   = ERASE;
                                w_pend_after_n = DRAW;
`endif
                            end
                            CC_LF: begin
                                w_newline    = 1'b1;
                                w_state_next = CLR_ROW;
`ifdef CONSOLE_CURSOR_EN
                                w_state_next   = ERASE;
                                w_pend_after_n = CLR_ROW;
`endif
                            end
                            CC_BS: begin
                                if (w_col != '0) begin
                                    w_dec         = 1'b1;
                                    w_pend_we_n   = 1'b1;
                                    w_pend_addr_n = cell_addr(w_row, w_col - 1'b1);
                                    w_pend_data_n = BLANK;
`ifdef CONSOLE_CURSOR_EN
                                    w_pend_draw_n  = 1'b1;
                                    w_state_next   = ERASE;
                                    w_pend_after_n = WRITE;
`endif
                                end
                            end
                            CC_FF: begin
                                w_home       = 1'b1;
                                w_state_next = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                w_we   = r_pend_we;
                w_addr = r_pend_addr;
                w_data = r_pend_data;
                if (r_pend_adv) begin
                    w_state_next = CLR_ROW;
                end else begin
`ifdef CONSOLE_CURSOR_EN
                    w_state_next = r_pend_draw ? DRAW : IDLE;
`else
                    w_state_next = IDLE;
`endif
                end
            end
            CLR_ROW: begin
                w_we       = 1'b1;
                w_addr     = cell_addr(w_row, r_cnt[ROW_SHIFT-1:0]);
                w_data     = BLANK;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt[ROW_SHIFT-1:0] == ROW_SHIFT'(COLS - 1)) w_state_next = ST_AFTER_CLR;
            end
`ifdef CONSOLE_CURSOR_EN
            ERASE: begin
                w_we         = 1'b1;
                w_addr       = r_erase_addr;
                w_data       = BLANK;
                w_state_next = r_pend_after;
            end
            DRAW: begin
                w_we         = 1'b1;
                w_addr       = w_cur_addr;
                w_data       = CURSOR_GLYPH;
                w_state_next = IDLE;
            end
`endif
            default: w_state_next = CLR_ALL;
        endcase
    end

    // State, clear counter and pending-write registers.
    always_ff @(posedge clk50_in or posedge rst) begin
        if (rst) begin
            r_state     <= CLR_ALL;
            r_cnt       <= '0;
            r_pend_we   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_pend_adv  <= 1'b0;
`ifdef CONSOLE_CURSOR_EN
            r_pend_draw  <= 1'b0;
            r_erase_addr <= '0;
            r_pend_after <= IDLE;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_pend_we   <= w_pend_we_n;
            r_pend_addr <= w_pend_addr_n;
            r_pend_data <= w_pend_data_n;
            r_pend_adv  <= w_pend_adv_n;
`ifdef CONSOLE_CURSOR_EN
            r_pend_draw  <= w_pend_draw_n;
            r_erase_addr <= w_erase_addr_n;
            r_pend_after <= w_pend_after_n;
`endif
        end
    end

    // Registered vmem write port.
    always_ff @(posedge clk50_in or posedge rst) begin
        if (rst) begin
            r_vmem_we   <= 1'b0;
            r_vmem_addr <= '0;
            r_vmem_data <= '0;
        end else begin
            r_vmem_we   <= w_we;
            r_vmem_addr <= w_addr;
            r_vmem_data <= w_data;
        end
    end

endmodule
